// File: rtl/vga_fb_port_arbiter_pkg.sv
// Shared definitions for the VGA framebuffer port arbiter.
// Contents: framebuffer geometry, RAM address/pixel widths, CPU write FIFO
// depth, the 3-bit {R,G,B} colour constants and the clear FSM state encoding.
package vga_fb_port_arbiter_pkg;

  localparam int FB_COLS     = 400;
  localparam int FB_ROWS     = 240;
  localparam int ADDR_W      = 17;
  localparam int COLOR_W     = 3;
  localparam int WFIFO_DEPTH = 4;

  localparam logic [2:0] COLOR_BLACK   = 3'b000;
  localparam logic [2:0] COLOR_BLUE    = 3'b001;
  localparam logic [2:0] COLOR_GREEN   = 3'b010;
  localparam logic [2:0] COLOR_CYAN    = 3'b011;
  localparam logic [2:0] COLOR_RED     = 3'b100;
  localparam logic [2:0] COLOR_MAGENTA = 3'b101;
  localparam logic [2:0] COLOR_YELLOW  = 3'b110;
  localparam logic [2:0] COLOR_WHITE   = 3'b111;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clear_state_t;

  // Saturating increment for the 8-bit clipped-write counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hff) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/vga_fb_port_arbiter_if.sv
// Bus bundle between the arbiter and its three neighbours: CPU pixel writes,
// VGA scan-out fetch, clear control/status and the single-port framebuffer RAM.
//
// Handshake: the CPU write channel is valid/ready. A write is transferred in
// every cycle where wr_valid and wr_ready are both high at the rising edge;
// wr_valid may be held across cycles and its payload (wr_row, wr_col,
// wr_color) must stay stable until transferred. wr_ready does not depend on
// wr_valid. The fetch channel has no ready: rd_req is always served and
// rd_valid/rd_data follow exactly one cycle later.
//
// Modports: slave = the arbiter, master = the CPU/VGA/RAM side.
interface vga_fb_port_arbiter_if
  import vga_fb_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = vga_fb_port_arbiter_pkg::ADDR_W,
  parameter int COLOR_W = vga_fb_port_arbiter_pkg::COLOR_W
);
  // CPU pixel writes
  logic               wr_valid;
  logic               wr_ready;
  logic [15:0]        wr_row;
  logic [15:0]        wr_col;
  logic [COLOR_W-1:0] wr_color;
  // scan-out fetch
  logic               rd_req;
  logic [15:0]        rd_row;
  logic [15:0]        rd_col;
  logic               rd_valid;
  logic [COLOR_W-1:0] rd_data;
  // clear engine
  logic               clear_start;
  logic [COLOR_W-1:0] clear_color;
  logic               clear_busy;
  logic               clear_done;
  logic [7:0]         clip_count;
  // framebuffer RAM port
  logic [ADDR_W-1:0]  ram_addr;
  logic               ram_we;
  logic [COLOR_W-1:0] ram_wdata;
  logic [COLOR_W-1:0] ram_rdata;

  modport slave (
    input  wr_valid, wr_row, wr_col, wr_color,
    output wr_ready,
    input  rd_req, rd_row, rd_col,
    output rd_valid, rd_data,
    input  clear_start, clear_color,
    output clear_busy, clear_done, clip_count,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output wr_valid, wr_row, wr_col, wr_color,
    input  wr_ready,
    output rd_req, rd_row, rd_col,
    input  rd_valid, rd_data,
    output clear_start, clear_color,
    input  clear_busy, clear_done, clip_count,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/vga_fb_port_arbiter_fb_wr_fifo.sv
// fb_wr_fifo: synchronous FIFO holding queued CPU pixel writes {addr, color}.
// Ports: clk, rst (sync, active high), push/din, pop/dout (dout shows the head
// combinationally), full/empty decoded from the registered occupancy count.
// DEPTH must be a power of two and at least 2 so pointers wrap naturally.
module fb_wr_fifo #(
  parameter int W     = 20,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_W'(1);
      if (do_pop)  rptr <= rptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/vga_fb_port_arbiter.sv
// vga_fb_port_arbiter: owns the single-port framebuffer RAM and shares it
// between VGA scan-out fetches (absolute priority), the hardware clear engine
// and buffered CPU pixel writes, in that order.
// Ports: clk, rst (sync, active high); bus (slave side of
// vga_fb_port_arbiter_if: CPU writes, fetch, clear control, RAM port);
// clear_state exposes the clear FSM state for observation.
module vga_fb_port_arbiter
  import vga_fb_port_arbiter_pkg::*;
#(
  parameter int FB_COLS     = vga_fb_port_arbiter_pkg::FB_COLS,
  parameter int FB_ROWS     = vga_fb_port_arbiter_pkg::FB_ROWS,
  parameter int ADDR_W      = vga_fb_port_arbiter_pkg::ADDR_W,
  parameter int COLOR_W     = vga_fb_port_arbiter_pkg::COLOR_W,
  parameter int WFIFO_DEPTH = vga_fb_port_arbiter_pkg::WFIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst,
  vga_fb_port_arbiter_if.slave   bus,
  output clear_state_t           clear_state
);
  localparam int                FIFO_W    = ADDR_W + COLOR_W;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FB_COLS * FB_ROWS - 1);

  clear_state_t       state;
  logic [ADDR_W-1:0]  clear_addr;
  logic [COLOR_W-1:0] clear_color_q;
  logic               clear_busy_q;
  logic               clear_done_q;
  logic [7:0]         clip_q;
  logic               rd_valid_q;
  logic [ADDR_W-1:0]  last_addr;

  logic               wr_take;
  logic               wr_in_range;
  logic [ADDR_W-1:0]  wr_addr;
  logic [ADDR_W-1:0]  rd_addr;
  logic               fifo_push;
  logic               fifo_pop;
  logic               fifo_full;
  logic               fifo_empty;
  logic [FIFO_W-1:0]  fifo_dout;
  logic [ADDR_W-1:0]  head_addr;
  logic [COLOR_W-1:0] head_color;
  logic               clear_write;

  // CPU write intake: out-of-range pixels are consumed but never queued.
  assign wr_take     = bus.wr_valid & bus.wr_ready;
  assign wr_in_range = (bus.wr_row < 16'(FB_ROWS)) && (bus.wr_col < 16'(FB_COLS));
  assign wr_addr     = ADDR_W'(bus.wr_row) * ADDR_W'(FB_COLS) + ADDR_W'(bus.wr_col);
  assign rd_addr     = ADDR_W'(bus.rd_row) * ADDR_W'(FB_COLS) + ADDR_W'(bus.rd_col);
  assign fifo_push   = wr_take & wr_in_range & ~rst;

  // Slot arbitration. A fetch wins outright; the clear engine owns every
  // remaining slot while it runs, so the FIFO only drains once it is idle.
  assign clear_write = ~rst & ~bus.rd_req & (state == ST_CLEAR);
  assign fifo_pop    = ~rst & ~bus.rd_req & (state != ST_CLEAR) & ~fifo_empty;

  assign {head_addr, head_color} = fifo_dout;

  fb_wr_fifo #(
    .W     (FIFO_W),
    .DEPTH (WFIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   ({wr_addr, bus.wr_color}),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // RAM port is driven straight from the arbitration decision; an idle slot
  // keeps the previous address on the bus.
  always_comb begin
    bus.ram_addr  = last_addr;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = COLOR_BLACK;
    if (bus.rd_req) begin
      bus.ram_addr = rd_addr;
    end else if (clear_write) begin
      bus.ram_addr  = clear_addr;
      bus.ram_we    = 1'b1;
      bus.ram_wdata = clear_color_q;
    end else if (fifo_pop) begin
      bus.ram_addr  = head_addr;
      bus.ram_we    = 1'b1;
      bus.ram_wdata = head_color;
    end
  end

  // Clear FSM with its registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      clear_addr    <= '0;
      clear_color_q <= COLOR_BLACK;
      clear_busy_q  <= 1'b0;
      clear_done_q  <= 1'b0;
    end else begin
      clear_done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.clear_start) begin
            state         <= ST_CLEAR;
            clear_addr    <= '0;
            clear_color_q <= bus.clear_color;
            clear_busy_q  <= 1'b1;
          end
        end
        ST_CLEAR: begin
          // A slot lost to a fetch simply delays the sweep by one cycle.
          if (clear_write) begin
            if (clear_addr == LAST_ADDR) begin
              state        <= ST_IDLE;
              clear_busy_q <= 1'b0;
              clear_done_q <= 1'b1;
            end else begin
              clear_addr <= clear_addr + ADDR_W'(1);
            end
          end
        end
        default: begin
          state        <= ST_IDLE;
          clear_busy_q <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      clip_q     <= '0;
      rd_valid_q <= 1'b0;
      last_addr  <= '0;
    end else begin
      if (wr_take && !wr_in_range) begin
        clip_q <= sat_inc8(clip_q);
      end
      rd_valid_q <= bus.rd_req;
      last_addr  <= bus.ram_addr;
    end
  end

  // RAM read data arrives one cycle after the fetch address.
  assign bus.rd_valid   = rd_valid_q;
  assign bus.rd_data    = rd_valid_q ? bus.ram_rdata : COLOR_BLACK;
  assign bus.wr_ready   = ~fifo_full;
  assign bus.clear_busy = clear_busy_q;
  assign bus.clear_done = clear_done_q;
  assign bus.clip_count = clip_q;
  assign clear_state    = state;

endmodule

// File: tb/tb_vga_fb_port_arbiter.sv
// Testbench for vga_fb_port_arbiter. A 24-row frame keeps the full clear
// sweep short; column width and addressing are the default 400-pixel layout.
// The reference model tracks the CPU write queue, clear progress, clip count
// and expected framebuffer contents, and predicts every RAM slot from the
// priority rules (fetch > clear > queued write > idle).
module tb_vga_fb_port_arbiter;
  import vga_fb_port_arbiter_pkg::*;

  localparam int COLS  = 400;
  localparam int ROWS  = 24;
  localparam int PIX   = COLS * ROWS;
  localparam int AW    = 17;
  localparam int CW    = 3;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  clear_state_t dbg_state;

  always #5 clk = ~clk;

  vga_fb_port_arbiter_if #(.ADDR_W(AW), .COLOR_W(CW)) bus ();

  vga_fb_port_arbiter #(
    .FB_COLS     (COLS),
    .FB_ROWS     (ROWS),
    .ADDR_W      (AW),
    .COLOR_W     (CW),
    .WFIFO_DEPTH (DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus.slave),
    .clear_state (dbg_state)
  );

  // Framebuffer RAM with one-cycle read latency.
  logic [CW-1:0] ram_mem [PIX];
  always @(posedge clk) begin
    if (bus.ram_we && int'(bus.ram_addr) < PIX) ram_mem[bus.ram_addr] <= bus.ram_wdata;
    if (int'(bus.ram_addr) < PIX) bus.ram_rdata <= ram_mem[bus.ram_addr];
    else                          bus.ram_rdata <= '0;
  end

  // ---------------- scoreboard / model ----------------
  logic [AW+CW-1:0] exp_q[$];
  logic [CW-1:0]    model_mem [PIX];
  bit               m_clearing;
  int               m_clr_ptr;
  logic [CW-1:0]    m_clr_color;
  int               m_clip;
  int               m_last;
  bit               m_rd_pend;
  logic [CW-1:0]    m_rd_data;
  bit               m_done;
  int               cyc;
  int               total;
  int               bad;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int lin(input int r, input int c);
    return r * COLS + c;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_clearing = 0;
    m_clr_ptr  = 0;
    m_clip     = 0;
    m_last     = 0;
    m_rd_pend  = 0;
    m_rd_data  = '0;
    m_done     = 0;
  endtask

  // One clock: check DUT outputs against the model, advance the model, clock.
  task automatic cycle();
    int               op_addr;
    bit               op_we;
    logic [CW-1:0]    op_data;
    bit               popq;
    bit               exp_ready;
    logic [AW+CW-1:0] head;
    #1;
    if (rst) begin
      check("rst_no_write", bus.ram_we, 0);
      model_reset();
    end else begin
      exp_ready = (exp_q.size() < DEPTH);
      op_we = 0; op_addr = m_last; op_data = '0; popq = 0;
      if (bus.rd_req) begin
        op_addr = lin(bus.rd_row, bus.rd_col);
      end else if (m_clearing) begin
        op_we = 1; op_addr = m_clr_ptr; op_data = m_clr_color;
      end else if (exp_q.size() > 0) begin
        head = exp_q[0];
        op_we = 1; op_addr = int'(head[AW+CW-1:CW]); op_data = head[CW-1:0]; popq = 1;
      end
      check("wr_ready", bus.wr_ready, exp_ready);
      check("ram_we", bus.ram_we, op_we);
      check("ram_addr", bus.ram_addr, op_addr);
      if (op_we) check("ram_wdata", bus.ram_wdata, op_data);
      check("rd_valid", bus.rd_valid, m_rd_pend);
      check("rd_data", bus.rd_data, m_rd_pend ? m_rd_data : '0);
      check("clear_busy", bus.clear_busy, m_clearing);
      check("clear_done", bus.clear_done, m_done);
      check("clip_count", bus.clip_count, m_clip);
      // advance the model
      if (popq) void'(exp_q.pop_front());
      if (op_we) model_mem[op_addr] = op_data;
      m_rd_pend = bus.rd_req;
      if (bus.rd_req) m_rd_data = model_mem[op_addr];
      m_done = 0;
      if (m_clearing) begin
        if (!bus.rd_req) begin
          if (m_clr_ptr == PIX - 1) begin
            m_clearing = 0;
            m_done     = 1;
          end else begin
            m_clr_ptr++;
          end
        end
      end else if (bus.clear_start) begin
        m_clearing  = 1;
        m_clr_ptr   = 0;
        m_clr_color = bus.clear_color;
      end
      if (bus.wr_valid && exp_ready) begin
        if (int'(bus.wr_row) < ROWS && int'(bus.wr_col) < COLS)
          exp_q.push_back({AW'(lin(bus.wr_row, bus.wr_col)), bus.wr_color});
        else if (m_clip < 255)
          m_clip++;
      end
      m_last = op_addr;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle();
    bus.wr_valid    = 0;
    bus.wr_row      = '0;
    bus.wr_col      = '0;
    bus.wr_color    = '0;
    bus.rd_req      = 0;
    bus.rd_row      = '0;
    bus.rd_col      = '0;
    bus.clear_start = 0;
    bus.clear_color = '0;
  endtask

  task automatic drive_wr(input int r, input int c, input logic [CW-1:0] col);
    bus.wr_valid = 1;
    bus.wr_row   = 16'(r);
    bus.wr_col   = 16'(c);
    bus.wr_color = col;
  endtask

  task automatic drive_rd(input int r, input int c);
    bus.rd_req = 1;
    bus.rd_row = 16'(r);
    bus.rd_col = 16'(c);
  endtask

  task automatic compare_mem(input string tag);
    int miss = 0;
    for (int a = 0; a < PIX; a++) if (ram_mem[a] !== model_mem[a]) miss++;
    check(tag, miss, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int start_cyc;
    total = 0; bad = 0; cyc = 0;
    for (int a = 0; a < PIX; a++) begin
      ram_mem[a]   = '0;
      model_mem[a] = '0;
    end
    model_reset();
    idle();
    rst = 1;
    @(posedge clk); #1;
    cycle();
    cycle();
    rst = 0;
    #1;
    check("rst_wr_ready", bus.wr_ready, 1);
    check("rst_rd_valid", bus.rd_valid, 0);
    check("rst_rd_data", bus.rd_data, 0);
    check("rst_busy", bus.clear_busy, 0);
    check("rst_done", bus.clear_done, 0);
    check("rst_clip", bus.clip_count, 0);
    check("rst_we", bus.ram_we, 0);
    check("rst_addr", bus.ram_addr, 0);
    check("rst_wdata", bus.ram_wdata, 0);
    check("rst_state", dbg_state, ST_IDLE);

    // single write
    drive_wr(2, 5, 3'b100);
    cycle();
    idle();
    #1;
    check("t1_we", bus.ram_we, 1);
    check("t1_addr", bus.ram_addr, 805);
    check("t1_wdata", bus.ram_wdata, 3'b100);
    cycle();

    // fetch priority holds writes back until the FIFO fills
    drive_rd($urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1));
    for (int i = 0; i < 4; i++) begin
      drive_wr($urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1), CW'($urandom_range(0, 7)));
      cycle();
    end
    bus.wr_valid = 0;
    #1;
    check("t2_full", bus.wr_ready, 0);
    check("t2_no_we", bus.ram_we, 0);
    cycle();
    bus.rd_req = 0;
    repeat (6) cycle();

    // fetch of a known pixel
    drive_wr(1, 1, 3'b010);
    cycle();
    idle();
    cycle();
    drive_rd(1, 1);
    #1;
    check("t3_addr", bus.ram_addr, 401);
    cycle();
    idle();
    #1;
    check("t3_valid", bus.rd_valid, 1);
    check("t3_data", bus.rd_data, 3'b010);
    cycle();

    // clipping
    drive_wr(ROWS, 0, 3'b111);
    cycle();
    drive_wr(0, COLS, 3'b111);
    cycle();
    idle();
    #1;
    check("t4_clip2", bus.clip_count, 2);
    check("t4_no_we", bus.ram_we, 0);
    cycle();
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) != 0)
        drive_wr(ROWS + $urandom_range(0, 60000), $urandom_range(0, 65535), CW'($urandom_range(0, 7)));
      else
        drive_wr($urandom_range(0, 65535), COLS + $urandom_range(0, 60000), CW'($urandom_range(0, 7)));
      cycle();
    end
    idle();
    #1;
    check("t4_sat", bus.clip_count, 255);
    cycle();

    // full clear with one fetch stall, one queued write and an ignored restart
    bus.clear_start = 1;
    bus.clear_color = 3'b001;
    start_cyc = cyc;
    cycle();
    idle();
    #1;
    check("t5_busy", bus.clear_busy, 1);
    check("t5_state", dbg_state, ST_CLEAR);
    repeat (10) cycle();
    drive_wr(5, 7, 3'b110);
    cycle();
    idle();
    repeat (50) cycle();
    bus.clear_start = 1;
    bus.clear_color = 3'b101;
    cycle();
    idle();
    repeat (50) cycle();
    drive_rd(3, 3);
    cycle();
    idle();
    n = 0;
    while (m_clearing && n < PIX + 50) begin
      cycle();
      n++;
    end
    check("t5_finished", m_clearing, 0);
    #1;
    check("t5_done", bus.clear_done, 1);
    check("t5_len", cyc - start_cyc, PIX + 2);
    check("t5_q_we", bus.ram_we, 1);
    check("t5_q_addr", bus.ram_addr, lin(5, 7));
    cycle();
    check("t5_done_once", bus.clear_done, 0);
    check("t5_pix0", ram_mem[0], 3'b001);
    check("t5_pix_last", ram_mem[PIX - 1], 3'b001);
    check("t5_pix_q", ram_mem[lin(5, 7)], 3'b110);
    compare_mem("t5_mem");

    // reset during a clear with writes still queued
    bus.clear_start = 1;
    bus.clear_color = 3'b011;
    cycle();
    idle();
    drive_wr(2, 2, 3'b111);
    cycle();
    drive_wr(3, 9, 3'b010);
    cycle();
    idle();
    repeat (20) cycle();
    rst = 1;
    cycle();
    rst = 0;
    #1;
    check("t6_busy", bus.clear_busy, 0);
    check("t6_ready", bus.wr_ready, 1);
    check("t6_we", bus.ram_we, 0);
    check("t6_clip", bus.clip_count, 0);
    repeat (8) cycle();

    // randomized traffic
    for (int i = 0; i < 2000; i++) begin
      idle();
      if ($urandom_range(0, 99) < 60) begin
        if ($urandom_range(0, 9) == 0)
          drive_wr($urandom_range(0, 2 * ROWS), $urandom_range(0, 2 * COLS), CW'($urandom_range(0, 7)));
        else
          drive_wr($urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1), CW'($urandom_range(0, 7)));
      end
      if ($urandom_range(0, 99) < 30)
        drive_rd($urandom_range(0, ROWS - 1), $urandom_range(0, COLS - 1));
      cycle();
    end
    idle();
    repeat (10) cycle();
    compare_mem("rand_mem");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/vga_fb_port_arbiter.md
Name: vga_fb_port_arbiter

Overview:
Owns the single-port framebuffer RAM behind the VGA text/pixel path and shares it between two requesters:
- the VGA scan-out fetch, which has hard real-time priority;
- the CPU `Display_VGA` pixel writes, buffered in a small FIFO.

It also provides a hardware clear engine that fills the whole framebuffer with one colour, so programs need not loop over every row and column. It sits between the CPU execute stage, the VGA timing/scan-out block and the framebuffer RAM.

Parameters:
- FB_COLS, 400, framebuffer width in pixels.
- FB_ROWS, 240, framebuffer height in pixels.
- ADDR_W, 17, RAM address width; must satisfy 2^ADDR_W >= FB_COLS*FB_ROWS.
- COLOR_W, 3, pixel width in bits, {R,G,B}.
- WFIFO_DEPTH, 4, CPU write FIFO depth; must be a power of 2.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- iWrValid  in  1  CPU pixel-write request.
- oWrReady  out  1  write FIFO can accept; a write is taken when iWrValid & oWrReady.
- iWrRow  in  16  pixel row (CPU register value).
- iWrCol  in  16  pixel column (CPU register value).
- iWrColor  in  COLOR_W  pixel colour.
- iRdReq  in  1  scan-out fetch this cycle.
- iRdRow  in  16  fetch row.
- iRdCol  in  16  fetch column.
- oRdValid  out  1  fetch data valid.
- oRdData  out  COLOR_W  fetched pixel.
- iClearStart  in  1  start a full-frame clear.
- iClearColor  in  COLOR_W  clear colour, sampled at start.
- oClearBusy  out  1  clear in progress.
- oClearDone  out  1  one-cycle pulse when the clear completes.
- oClipCount  out  8  count of out-of-range CPU writes, saturating.
- oRamAddr  out  ADDR_W  RAM address.
- oRamWe  out  1  RAM write enable.
- oRamWData  out  COLOR_W  RAM write data.
- iRamRData  in  COLOR_W  RAM read data; 1-cycle latency.

Behaviour:

Reset values (after a Reset cycle):
- oWrReady=1, oRdValid=0, oRdData=0, oClearBusy=0, oClearDone=0, oClipCount=0.
- oRamWe=0, oRamAddr=0, oRamWData=0.
- FIFO empty; clear FSM in IDLE.

Address rule: addr = row*FB_COLS + col, computed at ADDR_W bits. Row/column inputs are 16 bits wide; only in-range values are ever mapped.

CPU write acceptance:
- oWrReady = !fifo_full, registered from the FIFO count.
- An accepted write with row>=FB_ROWS or col>=FB_COLS is consumed but not queued; oClipCount increments and saturates at 255.
- In-range writes are pushed as {addr, color}.

RAM port, priority per cycle:
1. iRdReq: oRamAddr = read address, oRamWe=0. One cycle later oRdValid=1 and oRdData=iRamRData. When oRdValid=0, oRdData=0. Scan-out is never stalled.
2. Else, state CLEAR: write iClearColor (latched at start) to clear_addr, then clear_addr++.
3. Else, FIFO non-empty: pop the head and write it (oRamWe=1).
4. Else: oRamWe=0, address held.

RAM outputs (oRamAddr/oRamWe/oRamWData) are combinational from the arbitration decision. A write accepted in cycle t reaches the RAM no earlier than cycle t+1.

FIFO rules:
- Simultaneous push and pop leaves the count unchanged.
- Push when full cannot occur, because oWrReady=0.
- Writes are applied strictly in FIFO order.

Clear FSM, states IDLE and CLEAR:
- IDLE -> CLEAR on iClearStart: clear_addr=0, colour latched, oClearBusy=1 from the next cycle.
- iClearStart while in CLEAR is ignored.
- CLEAR holds while clear_addr <= FB_COLS*FB_ROWS-1.
- After the write to the last address: return to IDLE, and oClearDone=1 for exactly one cycle, the cycle after that write. oClearBusy=0 in the same cycle.
- During CLEAR the FIFO still accepts writes until full but is not drained. Queued writes therefore land after the clear and overwrite it.

Reset mid-operation: the clear is aborted, the FIFO is flushed, the clip count is zeroed, and no RAM write is issued in the Reset cycle.

Decomposition:
- Shared package/definitions file: COLOR_* constants (already defined), FB_COLS, FB_ROWS, ADDR_W, COLOR_W, and the clear FSM state encodings.
- One sub-module, fb_wr_fifo: a synchronous FIFO of width ADDR_W+COLOR_W and depth WFIFO_DEPTH, with full/empty outputs and push/pop inputs.

Test Plan:
1. Single write: after Reset, write row=2, col=5, colour=3'b100 with iRdReq=0 -> next cycle oRamWe=1, oRamAddr=805, oRamWData=3'b100.
2. Read priority: hold iRdReq, push 4 writes -> oRamWe stays 0 and oWrReady=0 after the 4th. Drop iRdReq -> 4 consecutive writes in push order.
3. Fetch: iRdReq with row=1, col=1 and RAM returning 3'b010 -> oRamAddr=401, then oRdValid=1 and oRdData=3'b010 one cycle later.
4. Clip: write row=240, col=0 and row=0, col=400 -> both accepted, no RAM write, oClipCount=2. Force 300 clipped writes -> oClipCount=255.
5. Clear: iClearStart with colour 3'b001, one iRdReq mid-clear, one CPU write queued -> 96000 writes covering addresses 0..95999, oClearDone one cycle later than with no read, then the queued write lands after the clear.
6. Reset mid-clear with a non-empty FIFO -> next cycle oClearBusy=0, oWrReady=1, oRamWe=0, and no oClearDone pulse.
